// File: rtl/nios_led1_cpu_debug_pkg.sv
// Shared constants for the Nios II debug command path: one-hot action bit
// positions and virtual IR codes.
package nios_led1_cpu_debug_pkg;

  localparam int DBG_OP_W = 10;

  localparam int OP_OCIMEM_A       = 0;
  localparam int OP_NOACT_OCIMEM_A = 1;
  localparam int OP_OCIMEM_B       = 2;
  localparam int OP_BREAK_A        = 3;
  localparam int OP_NOACT_BREAK_A  = 4;
  localparam int OP_BREAK_B        = 5;
  localparam int OP_NOACT_BREAK_B  = 6;
  localparam int OP_BREAK_C        = 7;
  localparam int OP_NOACT_BREAK_C  = 8;
  localparam int OP_TRACECTRL      = 9;

  localparam int IR_OCIMEM = 0;
  localparam int IR_RSVD   = 1;
  localparam int IR_BREAK  = 2;
  localparam int IR_TRACE  = 3;

  typedef logic [DBG_OP_W-1:0] dbg_op_t;

endpackage

// File: rtl/nios_led1_cpu_debug_cmd_fifo.sv
// Synchronous power-of-two FIFO with occupancy level; a push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module nios_led1_cpu_debug_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == LVL_FULL);
  assign o_empty   = (r_level == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_rdata   = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage carries data only; occupancy tracking alone defines validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/nios_led1_cpu_debug_cmd_router.sv
// System-clock debug command front end: synchronises JTAG update levels,
// queues captured commands and routes the decoded head to a CPU debug unit.
module nios_led1_cpu_debug_cmd_router
  import nios_led1_cpu_debug_pkg::*;
#(
  parameter int SR_WIDTH      = 38,
  parameter int IR_WIDTH      = 2,
  parameter int NUM_CH        = 2,
  parameter int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int FIFO_DEPTH    = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int TRACECTRL_BIT = 15
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          vs_udr,
  input  logic                          vs_uir,
  input  logic [IR_WIDTH-1:0]           ir_in,
  input  logic [SR_WIDTH-1:0]           sr,
  input  logic [CH_W-1:0]               ch_sel,
  output logic [NUM_CH-1:0]             cmd_valid,
  input  logic [NUM_CH-1:0]             cmd_ready,
  output logic [SR_WIDTH-1:0]           cmd_jdo,
  output logic [IR_WIDTH-1:0]           cmd_ir,
  output logic [DBG_OP_W-1:0]           cmd_op,
  output logic [IR_WIDTH-1:0]           ir_q,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int T     = SR_WIDTH - 1;
  localparam int ENT_W = CH_W + IR_WIDTH + SR_WIDTH;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  function automatic logic [DBG_OP_W-1:0] decode_op(input logic [IR_WIDTH-1:0] ir,
                                                    input logic [SR_WIDTH-1:0] j);
    logic [DBG_OP_W-1:0] op;
    op = '0;
    case (int'(ir))
      IR_OCIMEM: begin
        op[OP_OCIMEM_A]       = ~j[T-2] &  j[T-3];
        op[OP_NOACT_OCIMEM_A] = ~j[T-2] & ~j[T-3];
        op[OP_OCIMEM_B]       =  j[T-2];
      end
      IR_BREAK: begin
        op[OP_BREAK_A]       = ~j[T-1] &  j[T];
        op[OP_NOACT_BREAK_A] = ~j[T-1] & ~j[T];
        op[OP_BREAK_B]       =  j[T-1] & ~j[T-2] &  j[T];
        op[OP_NOACT_BREAK_B] =  j[T-1] & ~j[T-2] & ~j[T];
        op[OP_BREAK_C]       =  j[T-1] &  j[T-2] &  j[T];
        op[OP_NOACT_BREAK_C] =  j[T-1] &  j[T-2] & ~j[T];
      end
      IR_TRACE: op[OP_TRACECTRL] = j[TRACECTRL_BIT];
      default:  op = '0;
    endcase
    return op;
  endfunction

  logic [SYNC_STAGES-1:0] r_udr_sync;
  logic [SYNC_STAGES-1:0] r_uir_sync;
  logic [SYNC_STAGES-1:0] r_settle;
  logic                   r_udr_d;
  logic                   r_uir_d;
  logic                   r_udr_arm;
  logic                   r_uir_arm;
  logic                   r_udr_pulse;
  logic                   r_uir_pulse;
  logic                   r_overflow;
  logic [IR_WIDTH-1:0]    r_ir_q;

  logic                   w_udr_lvl;
  logic                   w_uir_lvl;
  logic                   w_settled;
  logic [ENT_W-1:0]       w_wdata;
  logic [ENT_W-1:0]       w_rdata;
  logic [CH_W-1:0]        w_head_ch;
  logic [IR_WIDTH-1:0]    w_head_ir;
  logic [SR_WIDTH-1:0]    w_head_sr;
  logic [LVL_W-1:0]       w_level;
  logic                   w_full;
  logic                   w_empty;
  logic [NUM_CH-1:0]      w_valid;
  logic                   w_discard;
  logic                   w_pop;
  logic                   w_drop;

  assign w_udr_lvl = r_udr_sync[SYNC_STAGES-1];
  assign w_uir_lvl = r_uir_sync[SYNC_STAGES-1];
  assign w_settled = r_settle[SYNC_STAGES-1];

  // Stage p0: level synchronisers and rising-edge pulses. r_settle marks when
  // the synchroniser output reflects the real level after reset, so a level
  // already high at reset release is ignored until it has been seen low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_udr_sync  <= '0;
      r_uir_sync  <= '0;
      r_settle    <= '0;
      r_udr_d     <= 1'b0;
      r_uir_d     <= 1'b0;
      r_udr_arm   <= 1'b0;
      r_uir_arm   <= 1'b0;
      r_udr_pulse <= 1'b0;
      r_uir_pulse <= 1'b0;
    end else begin
      r_udr_sync  <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
      r_uir_sync  <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
      r_settle    <= {r_settle[SYNC_STAGES-2:0], 1'b1};
      r_udr_d     <= w_udr_lvl;
      r_uir_d     <= w_uir_lvl;
      r_udr_arm   <= r_udr_arm | (w_settled & ~w_udr_lvl);
      r_uir_arm   <= r_uir_arm | (w_settled & ~w_uir_lvl);
      r_udr_pulse <= w_udr_lvl & ~r_udr_d & r_udr_arm;
      r_uir_pulse <= w_uir_lvl & ~r_uir_d & r_uir_arm;
    end
  end

  // Stage p1: command capture into the queue, IR latch and overflow flag.
  assign w_wdata = {ch_sel, ir_in, sr};
  assign w_drop  = r_udr_pulse & w_full & ~w_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
      r_ir_q     <= '0;
    end else begin
      if (w_drop)           r_overflow <= 1'b1;
      else if (r_uir_pulse) r_overflow <= 1'b0;
      if (r_uir_pulse)      r_ir_q     <= ir_in;
    end
  end

  nios_led1_cpu_debug_cmd_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (r_udr_pulse),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Stage p2: head routing. Entries aimed at a non-existent channel are
  // silently popped so they cannot block the queue.
  assign {w_head_ch, w_head_ir, w_head_sr} = w_rdata;

  always_comb begin
    w_valid   = '0;
    w_discard = 1'b0;
    if (!w_empty) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (int'(w_head_ch) == c) w_valid[c] = 1'b1;
      end
      w_discard = (int'(w_head_ch) >= NUM_CH);
    end
  end

  assign w_pop = (|(w_valid & cmd_ready)) | w_discard;

  assign cmd_valid  = w_valid;
  assign cmd_jdo    = w_empty ? '0 : w_head_sr;
  assign cmd_ir     = w_empty ? '0 : w_head_ir;
  assign cmd_op     = w_empty ? '0 : decode_op(w_head_ir, w_head_sr);
  assign ir_q       = r_ir_q;
  assign fifo_level = w_level;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_nios_led1_cpu_debug_cmd_router.sv
// Scoreboard bench for the debug command router: stimulus queues expected
// commands, a negedge monitor checks each handshake against the queue head.
module tb_nios_led1_cpu_debug_cmd_router;

  localparam int S = 2;

  typedef struct packed {
    logic [1:0]  ch;
    logic [1:0]  ir;
    logic [37:0] jdo;
    logic [9:0]  op;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vs_udr;
  logic        vs_uir;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic [1:0]  ch_sel;
  logic [1:0]  cmd_valid;
  logic [1:0]  cmd_ready;
  logic [37:0] cmd_jdo;
  logic [1:0]  cmd_ir;
  logic [9:0]  cmd_op;
  logic [1:0]  ir_q;
  logic [2:0]  fifo_level;
  logic        overflow;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  // Hand-derived ir=2 decode for sr[37:35] = 0..7.
  logic [9:0] brk_exp [8] = '{10'h010, 10'h010, 10'h040, 10'h100,
                              10'h008, 10'h008, 10'h020, 10'h080};

  always #5 clk = ~clk;

  nios_led1_cpu_debug_cmd_router #(
    .SR_WIDTH      (38),
    .IR_WIDTH      (2),
    .NUM_CH        (2),
    .CH_W          (2),
    .FIFO_DEPTH    (4),
    .SYNC_STAGES   (S),
    .TRACECTRL_BIT (15)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .vs_udr     (vs_udr),
    .vs_uir     (vs_uir),
    .ir_in      (ir_in),
    .sr         (sr),
    .ch_sel     (ch_sel),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_jdo    (cmd_jdo),
    .cmd_ir     (cmd_ir),
    .cmd_op     (cmd_op),
    .ir_q       (ir_q),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every accepted head must match the oldest expected command.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && |(cmd_valid & cmd_ready)) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got valid %b jdo %0h, expected no command", cmd_valid, cmd_jdo);
      end else begin
        mon_e = sb.pop_front();
        check("sb_valid", 64'(cmd_valid), 64'(2'b01 << mon_e.ch));
        check("sb_jdo",   64'(cmd_jdo),   64'(mon_e.jdo));
        check("sb_ir",    64'(cmd_ir),    64'(mon_e.ir));
        check("sb_op",    64'(cmd_op),    64'(mon_e.op));
      end
    end
  end

  task automatic set_ready(input logic [1:0] v);
    @(posedge clk);
    #1 cmd_ready = v;
  endtask

  task automatic do_udr(input logic [1:0] ch, input logic [1:0] ir, input logic [37:0] s,
                        input logic [9:0] op, input bit expect_out);
    exp_t e;
    @(negedge clk);
    ch_sel = ch;
    ir_in  = ir;
    sr     = s;
    vs_udr = 1'b1;
    if (expect_out) begin
      e = '{ch: ch, ir: ir, jdo: s, op: op};
      sb.push_back(e);
    end
    repeat (5) @(negedge clk);
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while ((fifo_level != 0 || sb.size() != 0) && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check(name, 64'(cyc < 200), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    reset_n   = 1'b0;
    vs_udr    = 1'b0;
    vs_uir    = 1'b0;
    ir_in     = '0;
    sr        = '0;
    ch_sel    = '0;
    cmd_ready = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",    64'(cmd_valid),  64'(0));
    check("rst_jdo",      64'(cmd_jdo),    64'(0));
    check("rst_ir",       64'(cmd_ir),     64'(0));
    check("rst_op",       64'(cmd_op),     64'(0));
    check("rst_ir_q",     64'(ir_q),       64'(0));
    check("rst_level",    64'(fifo_level), 64'(0));
    check("rst_overflow", 64'(overflow),   64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);

    // Latency and channel routing of a single OCIMEM_A command.
    ch_sel = 2'd1;
    ir_in  = 2'd0;
    sr     = 38'h04_0000_0000;
    vs_udr = 1'b1;
    e = '{ch: 2'd1, ir: 2'd0, jdo: 38'h04_0000_0000, op: 10'h001};
    sb.push_back(e);
    repeat (S + 1) @(posedge clk);
    #1 check("lat_early", 64'(cmd_valid), 64'(2'b00));
    @(posedge clk);
    #1 check("lat_valid", 64'(cmd_valid), 64'(2'b10));
    cmd_ready = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    check("ready0_level", 64'(fifo_level), 64'(1));
    check("ready0_valid", 64'(cmd_valid),  64'(2'b10));
    cmd_ready = 2'b10;
    @(posedge clk);
    #1 check("pop_level", 64'(fifo_level), 64'(0));
    @(negedge clk);
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);

    // Decode sweep: ir=2 over sr[37:35], then trace and reserved IR.
    set_ready(2'b11);
    for (int v = 0; v < 8; v++) begin
      logic [2:0] tb3;
      tb3 = 3'(v);
      do_udr(2'(v % 2), 2'd2, {tb3, 35'(v + 5)}, brk_exp[v], 1'b1);
    end
    do_udr(2'd0, 2'd3, 38'h00_0000_8000, 10'h200, 1'b1);
    do_udr(2'd1, 2'd3, 38'h3F_FFFF_7FFF, 10'h000, 1'b1);
    do_udr(2'd0, 2'd1, 38'h3F_FFFF_FFFF, 10'h000, 1'b1);
    wait_drain("sweep_drain");

    // Overflow: five updates into a four-deep queue with nobody ready.
    set_ready(2'b00);
    for (int i = 0; i < 5; i++) begin
      do_udr(2'd0, 2'd0, 38'(i + 1), 10'h002, i < 4);
    end
    check("ovf_level", 64'(fifo_level), 64'(4));
    check("ovf_flag",  64'(overflow),   64'(1));
    check("ovf_head",  64'(cmd_jdo),    64'(1));
    check("ovf_valid", 64'(cmd_valid),  64'(2'b01));
    @(negedge clk);
    ir_in  = 2'd3;
    vs_uir = 1'b1;
    repeat (6) @(negedge clk);
    check("uir_ovf_clr", 64'(overflow), 64'(0));
    check("uir_ir_q",    64'(ir_q),     64'(3));
    vs_uir = 1'b0;
    repeat (4) @(negedge clk);
    set_ready(2'b01);
    wait_drain("ovf_drain");

    // Push landing on a pop while full: level holds, nothing dropped.
    set_ready(2'b00);
    for (int i = 0; i < 4; i++) begin
      do_udr(2'd1, 2'd0, 38'h08_0000_0000 + 38'(i), 10'h004, 1'b1);
    end
    check("full_level", 64'(fifo_level), 64'(4));
    @(negedge clk);
    ch_sel = 2'd1;
    ir_in  = 2'd0;
    sr     = 38'h08_0000_0004;
    vs_udr = 1'b1;
    e = '{ch: 2'd1, ir: 2'd0, jdo: 38'h08_0000_0004, op: 10'h004};
    sb.push_back(e);
    repeat (3) @(posedge clk);
    #1 cmd_ready = 2'b10;
    @(posedge clk);
    #1;
    check("pushpop_level", 64'(fifo_level), 64'(4));
    check("pushpop_ovf",   64'(overflow),   64'(0));
    wait_drain("pushpop_drain");
    @(negedge clk);
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);

    // Entry for channel 3 is discarded; the next one is still delivered.
    set_ready(2'b11);
    @(negedge clk);
    ch_sel = 2'd3;
    ir_in  = 2'd0;
    sr     = 38'h04_0000_0000;
    vs_udr = 1'b1;
    repeat (S + 2) @(posedge clk);
    #1;
    check("disc_level", 64'(fifo_level), 64'(1));
    check("disc_valid", 64'(cmd_valid),  64'(2'b00));
    @(posedge clk);
    #1 check("disc_gone", 64'(fifo_level), 64'(0));
    @(negedge clk);
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);
    do_udr(2'd0, 2'd3, 38'h00_0000_8000, 10'h200, 1'b1);
    wait_drain("disc_drain");

    // Asynchronous reset with queued entries and update-DR held high.
    set_ready(2'b00);
    for (int i = 0; i < 3; i++) begin
      do_udr(2'd0, 2'd2, 38'h20_0000_0000 + 38'(i), 10'h008, 1'b1);
    end
    check("prerst_level", 64'(fifo_level), 64'(3));
    @(negedge clk);
    ch_sel = 2'd1;
    sr     = 38'h00_0000_0055;
    vs_udr = 1'b1;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("arst_valid",    64'(cmd_valid),  64'(0));
    check("arst_jdo",      64'(cmd_jdo),    64'(0));
    check("arst_ir",       64'(cmd_ir),     64'(0));
    check("arst_op",       64'(cmd_op),     64'(0));
    check("arst_ir_q",     64'(ir_q),       64'(0));
    check("arst_level",    64'(fifo_level), 64'(0));
    check("arst_overflow", 64'(overflow),   64'(0));
    sb.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("held_nopulse_level", 64'(fifo_level), 64'(0));
    check("held_nopulse_valid", 64'(cmd_valid),  64'(0));
    vs_udr = 1'b0;
    repeat (6) @(negedge clk);
    set_ready(2'b10);
    do_udr(2'd1, 2'd0, 38'h04_0000_0000, 10'h001, 1'b1);
    wait_drain("post_rst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
